// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared timing defaults, state encoding and dither helpers for lcd_timing_gen
package lcd_pkg;

  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_H_FP     = 40;
  localparam int LCD_H_SYNC   = 48;
  localparam int LCD_H_BP     = 40;
  localparam int LCD_V_ACTIVE = 480;
  localparam int LCD_V_FP     = 13;
  localparam int LCD_V_SYNC   = 1;
  localparam int LCD_V_BP     = 31;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // 2x2 Bayer offsets, one byte per cell, indexed by {y[0], x[0]}
  localparam logic [31:0] BAYER_RB = {8'd2, 8'd6, 8'd4, 8'd0};
  localparam logic [31:0] BAYER_G  = {8'd1, 8'd3, 8'd2, 8'd0};

  function automatic logic [7:0] bayer_rb(input logic [1:0] idx);
    return BAYER_RB[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] bayer_g(input logic [1:0] idx);
    return BAYER_G[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/lcd_delay_line.sv
// rtl/lcd_delay_line.sv - parametrised shift register; DEPTH=0 degenerates to a wire
module lcd_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             PixelClk,
  input  logic             nRST,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lcd_timing_gen.sv
// rtl/lcd_timing_gen.sv - RGB panel timing generator with source-latency compensation
// Define LCD_DITHER_EN to add 2x2 ordered dithering from RGB888 to RGB565.
module lcd_timing_gen
  import lcd_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int H_FP     = LCD_H_FP,
  parameter int H_SYNC   = LCD_H_SYNC,
  parameter int H_BP     = LCD_H_BP,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int V_FP     = LCD_V_FP,
  parameter int V_SYNC   = LCD_V_SYNC,
  parameter int V_BP     = LCD_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_LAT = 2
) (
  input  logic                          PixelClk,
  input  logic                          nRST,
  input  logic                          run,
  input  logic [23:0]                   rgb,
  output logic                          req_valid,
  output logic [$clog2(H_ACTIVE)-1:0]   req_x,
  output logic [$clog2(V_ACTIVE)-1:0]   req_y,
  output logic                          frame_start,
  output logic                          line_start,
  output logic [15:0]                   frame_cnt,
  output logic                          busy,
  output logic                          LCD_CLK,
  output logic                          LCD_DE,
  output logic                          LCD_HSYNC,
  output logic                          LCD_VSYNC,
  output logic [4:0]                    LCD_R,
  output logic [5:0]                    LCD_G,
  output logic [4:0]                    LCD_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int XW      = $clog2(H_ACTIVE);
  localparam int YW      = $clog2(V_ACTIVE);
  localparam int HS_BEG  = H_ACTIVE + H_FP;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FP;
  localparam int VS_END  = VS_BEG + V_SYNC;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [4:0]    DRAIN_LOAD = 5'(PIPE_LAT + 1);

  logic [1:0]    state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [4:0]    drain_cnt;
  logic [31:0]   h32, v32;
  logic          scanning, h_last, frame_last, in_active, v_active;
  logic          hs_raw, vs_raw;

  assign scanning   = (state != ST_IDLE);
  assign h_last     = (h == H_LAST);
  assign frame_last = h_last && (v == V_LAST);
  assign h32        = 32'(h);
  assign v32        = 32'(v);
  assign v_active   = (v32 < 32'(V_ACTIVE));
  assign in_active  = (h32 < 32'(H_ACTIVE)) && v_active;

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state     <= ST_IDLE;
      h         <= '0;
      v         <= '0;
      frame_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE:  if (run) state <= ST_RUN;
        ST_RUN:   if (!run) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (run)             state <= ST_RUN;
          else if (frame_last) state <= ST_IDLE;
        end
        default:  state <= ST_IDLE;
      endcase

      if (scanning) begin
        h <= h_last ? '0 : h + 1'b1;
        if (h_last) v <= (v == V_LAST) ? '0 : v + 1'b1;
        if (frame_last) frame_cnt <= frame_cnt + 16'd1;
      end

      // Keeps busy high until the last request has reached the pins
      if (scanning)               drain_cnt <= DRAIN_LOAD;
      else if (drain_cnt != 5'd0) drain_cnt <= drain_cnt - 5'd1;
    end
  end

  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      req_valid   <= 1'b0;
      req_x       <= '0;
      req_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hs_raw      <= 1'b0;
      vs_raw      <= 1'b0;
    end else begin
      req_valid   <= scanning && in_active;
      req_x       <= (scanning && in_active) ? h[XW-1:0] : '0;
      req_y       <= (scanning && in_active) ? v[YW-1:0] : '0;
      frame_start <= scanning && (h == '0) && (v == '0);
      line_start  <= scanning && (h == '0) && v_active;
      hs_raw      <= scanning && (h32 >= 32'(HS_BEG)) && (h32 < 32'(HS_END));
      vs_raw      <= scanning && (v32 >= 32'(VS_BEG)) && (v32 < 32'(VS_END));
    end
  end

  logic       de_d, hs_d, vs_d;
  logic [4:0] r_c, b_c;
  logic [5:0] g_c;

`ifdef LCD_DITHER_EN
  logic [1:0] cell_d;
  logic [7:0] r_sat, g_sat, b_sat;

  lcd_delay_line #(.WIDTH(5), .DEPTH(PIPE_LAT)) u_pipe (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .din      ({req_valid, hs_raw, vs_raw, req_y[0], req_x[0]}),
    .dout     ({de_d, hs_d, vs_d, cell_d})
  );

  assign r_sat = sat_add8(rgb[23:16], bayer_rb(cell_d));
  assign g_sat = sat_add8(rgb[15:8],  bayer_g(cell_d));
  assign b_sat = sat_add8(rgb[7:0],   bayer_rb(cell_d));
  assign r_c   = r_sat[7:3];
  assign g_c   = g_sat[7:2];
  assign b_c   = b_sat[7:3];
`else
  logic unused_rgb_lsbs;

  lcd_delay_line #(.WIDTH(3), .DEPTH(PIPE_LAT)) u_pipe (
    .PixelClk (PixelClk),
    .nRST     (nRST),
    .din      ({req_valid, hs_raw, vs_raw}),
    .dout     ({de_d, hs_d, vs_d})
  );

  assign r_c = rgb[23:19];
  assign g_c = rgb[15:10];
  assign b_c = rgb[7:3];
  assign unused_rgb_lsbs = ^{rgb[18:16], rgb[9:8], rgb[2:0]};
`endif

  // rgb arrives PIPE_LAT cycles after its request, so it lands here with the delayed controls
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      LCD_DE    <= 1'b0;
      LCD_HSYNC <= ~HS_POL;
      LCD_VSYNC <= ~VS_POL;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
    end else begin
      LCD_DE    <= de_d;
      LCD_HSYNC <= hs_d ^ ~HS_POL;
      LCD_VSYNC <= vs_d ^ ~VS_POL;
      LCD_R     <= de_d ? r_c : '0;
      LCD_G     <= de_d ? g_c : '0;
      LCD_B     <= de_d ? b_c : '0;
    end
  end

  assign busy    = scanning || (drain_cnt != 5'd0);
  assign LCD_CLK = PixelClk;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb/tb_lcd_timing_gen.sv - bench for lcd_timing_gen on a 7x6 geometry, two latency/polarity variants
module tb_lcd_timing_gen;

  logic        clk = 1'b0;
  logic        nRST;
  logic        run;
  logic [23:0] rgb_a, rgb_b;

  logic        a_rv, a_fs, a_ls, a_busy, a_lclk, a_de, a_hs, a_vs;
  logic [1:0]  a_rx, a_ry;
  logic [15:0] a_fc;
  logic [4:0]  a_r, a_b;
  logic [5:0]  a_g;

  logic        b_rv, b_fs, b_ls, b_busy, b_lclk, b_de, b_hs, b_vs;
  logic [1:0]  b_rx, b_ry;
  logic [15:0] b_fc;
  logic [4:0]  b_r, b_b;
  logic [5:0]  b_g;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_LAT(3)
  ) u_a (
    .PixelClk(clk), .nRST(nRST), .run(run), .rgb(rgb_a),
    .req_valid(a_rv), .req_x(a_rx), .req_y(a_ry),
    .frame_start(a_fs), .line_start(a_ls), .frame_cnt(a_fc), .busy(a_busy),
    .LCD_CLK(a_lclk), .LCD_DE(a_de), .LCD_HSYNC(a_hs), .LCD_VSYNC(a_vs),
    .LCD_R(a_r), .LCD_G(a_g), .LCD_B(a_b)
  );

  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIPE_LAT(2)
  ) u_b (
    .PixelClk(clk), .nRST(nRST), .run(run), .rgb(rgb_b),
    .req_valid(b_rv), .req_x(b_rx), .req_y(b_ry),
    .frame_start(b_fs), .line_start(b_ls), .frame_cnt(b_fc), .busy(b_busy),
    .LCD_CLK(b_lclk), .LCD_DE(b_de), .LCD_HSYNC(b_hs), .LCD_VSYNC(b_vs),
    .LCD_R(b_r), .LCD_G(b_g), .LCD_B(b_b)
  );

  // Pixel source for u_a: answers each request three cycles later with colours encoding x/y
  logic [1:0] hx_a [3];
  logic [1:0] hy_a [3];
  logic [3:0] sum_a;
  always @(posedge clk) begin
    hx_a[0] <= a_rx; hx_a[1] <= hx_a[0]; hx_a[2] <= hx_a[1];
    hy_a[0] <= a_ry; hy_a[1] <= hy_a[0]; hy_a[2] <= hy_a[1];
  end
  assign sum_a = {2'b00, hx_a[2]} + {2'b00, hy_a[2]};
  assign rgb_a = {1'b1, 2'b00, hx_a[2], 3'b001, 1'b1, 1'b0, sum_a, 2'b00, 1'b1, 2'b00, hy_a[2], 3'b001};

  typedef struct {
    int   cyc;
    logic rv; logic [1:0] rx; logic [1:0] ry; logic fs; logic ls;
    logic de; logic hs; logic vs;
  } vec_t;

  typedef struct {
    logic [23:0] rgb; logic [1:0] idx;
    logic [4:0] r; logic [5:0] g; logic [4:0] b;
  } cell_t;

  vec_t  vecs [13];
  cell_t cells [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit pix(input int p, output int h, output int v);
    h = 0;
    v = 0;
    if (p < 0 || p > 83) return 1'b0;
    h = p % 7;
    v = (p / 7) % 6;
    return 1'b1;
  endfunction

  function automatic logic [15:0] cell_exp(input logic [23:0] c, input logic [1:0] idx);
    for (int i = 0; i < 8; i++)
      if (cells[i].rgb == c && cells[i].idx == idx) return {cells[i].r, cells[i].g, cells[i].b};
    return 16'hFFFF;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_b_rv"}, b_rv, 0);   chk({tag, "_b_rx"}, b_rx, 0);
    chk({tag, "_b_ry"}, b_ry, 0);   chk({tag, "_b_fs"}, b_fs, 0);
    chk({tag, "_b_ls"}, b_ls, 0);   chk({tag, "_b_fc"}, b_fc, 0);
    chk({tag, "_b_busy"}, b_busy, 0); chk({tag, "_b_de"}, b_de, 0);
    chk({tag, "_b_hs"}, b_hs, 1);   chk({tag, "_b_vs"}, b_vs, 1);
    chk({tag, "_b_r"}, b_r, 0);     chk({tag, "_b_g"}, b_g, 0);
    chk({tag, "_a_hs"}, a_hs, 0);   chk({tag, "_a_vs"}, a_vs, 0);
    chk({tag, "_a_fc"}, a_fc, 0);   chk({tag, "_a_de"}, a_de, 0);
  endtask

  initial begin
    logic [15:0] e;
    int h, v;
    bit ok, e_de, e_rv;

    //            cyc rv rx ry fs ls de hs vs   (u_b, active-low syncs)
    vecs[0]  = '{ 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[1]  = '{ 1, 1, 0, 0, 1, 1, 0, 1, 1};
    vecs[2]  = '{ 2, 1, 1, 0, 0, 0, 0, 1, 1};
    vecs[3]  = '{ 4, 1, 3, 0, 0, 0, 1, 1, 1};
    vecs[4]  = '{ 5, 0, 0, 0, 0, 0, 1, 1, 1};
    vecs[5]  = '{ 8, 1, 0, 1, 0, 1, 0, 1, 1};
    vecs[6]  = '{ 9, 1, 1, 1, 0, 0, 0, 0, 1};
    vecs[7]  = '{11, 1, 3, 1, 0, 0, 1, 1, 1};
    vecs[8]  = '{22, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[9]  = '{32, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[10] = '{38, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[11] = '{39, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[12] = '{43, 1, 0, 0, 1, 1, 0, 1, 1};

    cells[0] = '{24'hFDFDFD, 2'd0, 5'd31, 6'd63, 5'd31};
    cells[1] = '{24'hFDFDFD, 2'd1, 5'd31, 6'd63, 5'd31};
    cells[2] = '{24'hFDFDFD, 2'd2, 5'd31, 6'd63, 5'd31};
    cells[3] = '{24'hFDFDFD, 2'd3, 5'd31, 6'd63, 5'd31};
`ifdef LCD_DITHER_EN
    cells[4] = '{24'h050505, 2'd0, 5'd0, 6'd1, 5'd0};
    cells[5] = '{24'h050505, 2'd1, 5'd1, 6'd1, 5'd1};
    cells[6] = '{24'h050505, 2'd2, 5'd1, 6'd2, 5'd1};
    cells[7] = '{24'h050505, 2'd3, 5'd0, 6'd1, 5'd0};
`else
    cells[4] = '{24'h050505, 2'd0, 5'd0, 6'd1, 5'd0};
    cells[5] = '{24'h050505, 2'd1, 5'd0, 6'd1, 5'd0};
    cells[6] = '{24'h050505, 2'd2, 5'd0, 6'd1, 5'd0};
    cells[7] = '{24'h050505, 2'd3, 5'd0, 6'd1, 5'd0};
`endif

    nRST  = 1'b0;
    run   = 1'b0;
    rgb_b = 24'hFDFDFD;
    repeat (3) @(negedge clk);
    check_reset("rst");
    nRST = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", b_busy, 0);
    chk("idle_rv", b_rv, 0);
    run = 1'b1;

    // Two frames: one-cycle run dip at c=20, stop requested at c=50 inside frame 2
    for (int c = 0; c <= 110; c++) begin
      @(negedge clk);
      ok   = pix(c - 4, h, v);
      e_de = ok && h < 4 && v < 3;
      e    = cell_exp((c - 4 < 42) ? 24'hFDFDFD : 24'h050505, 2'((v % 2) * 2 + (h % 2)));
      chk($sformatf("b_de@%0d", c), b_de, e_de);
      chk($sformatf("b_hs@%0d", c), b_hs, !(ok && h == 5));
      chk($sformatf("b_vs@%0d", c), b_vs, !(ok && v == 4));
      chk($sformatf("b_rgb@%0d", c), {b_r, b_g, b_b}, e_de ? e : 16'd0);

      ok   = pix(c - 5, h, v);
      e_de = ok && h < 4 && v < 3;
      chk($sformatf("a_de@%0d", c), a_de, e_de);
      chk($sformatf("a_hs@%0d", c), a_hs, ok && h == 5);
      chk($sformatf("a_vs@%0d", c), a_vs, ok && v == 4);
      chk($sformatf("a_r@%0d", c), a_r, e_de ? 16 + h : 0);
      chk($sformatf("a_g@%0d", c), a_g, e_de ? 32 + h + v : 0);
      chk($sformatf("a_b@%0d", c), a_b, e_de ? 16 + v : 0);

      ok   = pix(c - 1, h, v);
      e_rv = ok && h < 4 && v < 3;
      chk($sformatf("b_rv@%0d", c), b_rv, e_rv);
      chk($sformatf("b_rx@%0d", c), b_rx, e_rv ? h : 0);
      chk($sformatf("b_ry@%0d", c), b_ry, e_rv ? v : 0);
      chk($sformatf("b_fs@%0d", c), b_fs, ok && h == 0 && v == 0);
      chk($sformatf("b_ls@%0d", c), b_ls, ok && h == 0 && v < 3);
      chk($sformatf("a_rv@%0d", c), a_rv, e_rv);
      chk($sformatf("b_busy@%0d", c), b_busy, c <= 86);
      chk($sformatf("a_busy@%0d", c), a_busy, c <= 87);

      if (c == 41 || c == 42 || c == 83 || c == 84) begin
        chk($sformatf("b_fc@%0d", c), b_fc, (c >= 84) ? 2 : (c >= 42) ? 1 : 0);
        chk($sformatf("a_fc@%0d", c), a_fc, (c >= 84) ? 2 : (c >= 42) ? 1 : 0);
      end

      for (int i = 0; i < 13; i++) begin
        if (vecs[i].cyc == c) begin
          chk($sformatf("vec%0d_rv", i), b_rv, vecs[i].rv);
          chk($sformatf("vec%0d_rx", i), b_rx, vecs[i].rx);
          chk($sformatf("vec%0d_ry", i), b_ry, vecs[i].ry);
          chk($sformatf("vec%0d_fs", i), b_fs, vecs[i].fs);
          chk($sformatf("vec%0d_ls", i), b_ls, vecs[i].ls);
          chk($sformatf("vec%0d_de", i), b_de, vecs[i].de);
          chk($sformatf("vec%0d_hs", i), b_hs, vecs[i].hs);
          chk($sformatf("vec%0d_vs", i), b_vs, vecs[i].vs);
        end
      end

      if (c == 20) run = 1'b0;
      if (c == 21) run = 1'b1;
      if (c == 45) rgb_b = 24'h050505;
      if (c == 50) run = 1'b0;
    end

    // Restart, then assert nRST mid-line while DE is high
    run = 1'b1;
    for (int c = 0; c <= 11; c++) @(negedge clk);
    chk("pre_rst_b_rv", b_rv, 1);
    chk("pre_rst_b_de", b_de, 1);
    chk("pre_rst_b_fc", b_fc, 2);
    #1 nRST = 1'b0;
    #1 check_reset("async");
    @(negedge clk);
    nRST = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("rs_rv0", b_rv, 0);
      if (c == 1) begin
        chk("rs_fs", b_fs, 1);
        chk("rs_rv1", b_rv, 1);
        chk("rs_rx", b_rx, 0);
        chk("rs_ry", b_ry, 0);
      end
      if (c == 4) begin
        chk("rs_b_de", b_de, 1);
        chk("rs_a_de4", a_de, 0);
        chk("rs_b_g", b_g, cells[4].g);
      end
      if (c == 5) begin
        chk("rs_a_de5", a_de, 1);
        chk("rs_a_r", a_r, 16);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_timing_gen.md
# lcd_timing_gen

Parametrised RGB-panel timing generator. It drives the TFT LCD port and issues pixel requests ahead of time to an upstream pixel source that has a fixed pipeline latency. The block sits between the frame/pattern source and the panel pins. It generalises fixed 800x480 active-high timing with these additions:
- configurable geometry and sync polarity
- source-latency compensation
- run/stop control that stops only at a frame boundary
- frame/line strobes and a frame counter
- optional ordered dithering from RGB888 to RGB565

## Interface
Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 48 / 40, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 13 / 1 / 31, vertical front porch / sync / back porch in lines
- HS_POL / VS_POL, 1 / 1, asserted level of LCD_HSYNC / LCD_VSYNC
- PIPE_LAT, 2, cycles from req_x/req_y to the matching rgb being valid; range 0..15

Ports:
- PixelClk  in  1  pixel clock, the only clock
- nRST  in  1  reset, asynchronous, active-low
- run  in  1  level; starts scanning, or requests a stop at the frame boundary
- rgb  in  24  RGB888 pixel for the request issued PIPE_LAT cycles earlier
- req_valid  out  1  request coordinate lies in the active area
- req_x  out  clog2(H_ACTIVE)  request X; 0 when req_valid is low
- req_y  out  clog2(V_ACTIVE)  request Y; 0 when req_valid is low
- frame_start  out  1  one-cycle pulse at request (0,0)
- line_start  out  1  one-cycle pulse at req_x==0 on every active line
- frame_cnt  out  16  count of completed frames, wraps
- busy  out  1  scanning, including the drain to the frame end
- LCD_CLK  out  1  equals PixelClk
- LCD_DE / LCD_HSYNC / LCD_VSYNC  out  1  panel controls
- LCD_R / LCD_G / LCD_B  out  5 / 6 / 5  panel data

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counter widths come from clog2 of the totals.
- Counters h and v are registered:
  - h wraps at H_TOTAL-1.
  - v increments on each h wrap and itself wraps at V_TOTAL-1.
- Request stage (registered, from h and v):
  - req_valid = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - req_x = h and req_y = v when valid, otherwise 0.
- Sync and DE are raw decodes taken at the request stage:
  - HSYNC raw when H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC.
  - VSYNC raw when V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC.
  - DE raw = req_valid.
- The raw decodes pass through a PIPE_LAT-deep shift register and then one output register.
- rgb is captured into the same output register, so pins and data stay aligned.
- Sync polarity: LCD_HSYNC = raw^~HS_POL; LCD_VSYNC likewise with VS_POL.
- LCD_R/G/B are forced to 0 whenever the delayed DE is low.
- Without dithering, the colour fields are truncated: R = rgb[23:19], G = rgb[15:10], B = rgb[7:3].
- State machine:
  - IDLE: counters held at 0, request stage invalid, pins at their inactive levels. Goes to RUN when run=1.
  - RUN: counters advance. Goes to DRAIN when run=0.
  - DRAIN: counters advance. Goes back to RUN if run=1. Goes to IDLE on the last pixel of the frame (h=H_TOTAL-1, v=V_TOTAL-1).
- busy = (state≠IDLE) OR (delay pipe not empty).
- frame_cnt increments at the last pixel of each frame, in both RUN and DRAIN.

## Timing
- Reset values:
  - state IDLE; h, v and the delay pipe all 0.
  - req_* 0, frame_start 0, line_start 0, frame_cnt 0, busy 0.
  - LCD_DE 0, LCD_R/G/B 0.
  - LCD_HSYNC = ~HS_POL, LCD_VSYNC = ~VS_POL.
- Run start: run sampled high at edge N gives the first request (0,0) with frame_start at N+1. LCD_DE for that pixel rises at N+2+PIPE_LAT.
- Latency from the request stage to the pins is PIPE_LAT+1 cycles, for every signal.
- With PIPE_LAT=0, rgb is sampled in the same cycle as its request.
- Stop: run low mid-frame finishes the frame. A run pulse 0 then 1 inside DRAIN does not restart or glitch timing.
- Reset mid-frame returns every output to its reset value immediately, asynchronously.

## Configuration
- LCD_DITHER_EN defined:
  - Adds a 2x2 Bayer offset before truncation, indexed by {req_y[0],req_x[0]} delayed through the pipe.
  - Offsets for R and B: 0/4/6/2 (index 00/01/10/11); offsets for G: 0/2/3/1.
  - The addition saturates at 255.
  - Latency does not change.
- LCD_DITHER_EN undefined: plain truncation, and no coordinate bits are carried down the pipe.

## Structure
- Shared package lcd_pkg holds:
  - the default 800x480 timing localparams
  - the state enum (IDLE/RUN/DRAIN)
  - the Bayer offset constants
- Sub-module lcd_delay_line: a parametrised shift register (WIDTH, DEPTH≥0) used for the sync/DE/coordinate pipe. DEPTH=0 is a wire.

## Test plan
- Small geometry (H 4/1/1/1, V 3/1/1/1, PIPE_LAT=2), run=1 → LCD_DE high 4 cycles per line on 3 of 6 lines; HSYNC asserted 1 cycle at line offset 5+3; first DE at N+4.
- HS_POL=0, VS_POL=0 → syncs idle high and pulse low; after reset both read 1.
- Source returns rgb = {req_x,req_y} with PIPE_LAT=3 → LCD_R/G/B match the coordinates of every DE pixel; 0 during blanking.
- run dropped at v=1 → scan continues to the frame end; frame_cnt +1; busy falls PIPE_LAT+1 cycles after state IDLE; no further DE.
- nRST asserted mid-line → all pins, req_* and frame_cnt at reset values in the same cycle; restart begins at (0,0).
- LCD_DITHER_EN, constant rgb=0xFDFDFD → R/B alternate between 31 (saturated) and 31 and G between 63 and 63; rgb=0x050505 → R values 0/1/1/0 across the 2x2 cell.
